// File: rtl/keypad_scan_controller.sv
// Key FIFO: small circular buffer holding decoded key codes for the consumer.
// Latency: a push is visible at head_dat/empty the cycle after it is written.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module keypad_key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Keypad scanner: walks a 4x4 matrix one row at a time, debounces, queues key codes.
// Latency: push in the EVAL of the DEBOUNCE_SCANS-th consistent scan, key_valid next cycle.
// Backpressure: key_valid/key_ready FIFO; a push into a full FIFO without a pop is dropped and flags overflow.
module keypad_scan_controller #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] columns,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow,
    input  logic       clr_overflow
);
    localparam int DCW = $clog2(SCAN_DIV);
    localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  DB_TARGET  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EVAL  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     row_idx, row_nxt;
    logic [DCW-1:0] dwell_cnt, dwell_nxt;
    logic [3:0]     rows_nxt;
    logic           cap_en;

    logic [3:0]     col_s1, col_s2;
    logic [15:0]    cap;

    logic [4:0]     zero_cnt;
    logic [3:0]     zero_pos;
    logic           is_single;
    logic [3:0]     scan_code;

    logic [CW-1:0]  press_cnt, rel_cnt;
    logic [CW-1:0]  press_inc, rel_inc;
    logic [3:0]     prev_code;
    logic           eval_act;
    logic           push;
    logic           pop;
    logic           fifo_empty, fifo_full;
    logic           drop;

    // Two-flop synchronizer for the asynchronous column inputs; idle columns read high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= columns;
            col_s2 <= col_s1;
        end
    end

    // Scan sequencer state, row index, dwell counter and registered row drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            rows      <= 4'hF;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_nxt;
            dwell_cnt <= dwell_nxt;
            rows      <= rows_nxt;
        end
    end

    // Next-state logic: dwell on each row, capture on the last dwell cycle, one EVAL cycle per scan.
    always_comb begin
        state_nxt = state;
        row_nxt   = row_idx;
        dwell_nxt = dwell_cnt;
        cap_en    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            row_nxt   = 2'd0;
            dwell_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = DRIVE;
                    row_nxt   = 2'd0;
                    dwell_nxt = '0;
                end
                DRIVE: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        cap_en    = 1'b1;
                        dwell_nxt = '0;
                        if (row_idx == 2'd3) begin
                            state_nxt = EVAL;
                            row_nxt   = 2'd0;
                        end else begin
                            row_nxt = row_idx + 2'd1;
                        end
                    end else begin
                        dwell_nxt = dwell_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    state_nxt = DRIVE;
                    row_nxt   = 2'd0;
                    dwell_nxt = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    row_nxt   = 2'd0;
                    dwell_nxt = '0;
                end
            endcase
        end
        // Row drive is registered so it tracks the state that is entered next cycle.
        rows_nxt = (state_nxt == DRIVE) ? ~(4'b0001 << row_nxt) : 4'hF;
    end

    // Capture buffer: one nibble of synchronized columns per row, row r at bits 4r+3..4r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap <= 16'hFFFF;
        end else if (cap_en) begin
            cap[{row_idx, 2'b00} +: 4] <= col_s2;
        end
    end

    // Scan classification: count pressed contacts and remember where the last one was.
    always_comb begin
        zero_cnt = 5'd0;
        zero_pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!cap[i]) begin
                zero_cnt = zero_cnt + 5'd1;
                zero_pos = 4'(i);
            end
        end
        is_single = (zero_cnt == 5'd1);
    end

    // Matrix position to keypad legend.
    always_comb begin
        scan_code = 4'h0;
        case (zero_pos)
            4'd0:  scan_code = 4'h1;
            4'd1:  scan_code = 4'h2;
            4'd2:  scan_code = 4'h3;
            4'd3:  scan_code = 4'hA;
            4'd4:  scan_code = 4'h4;
            4'd5:  scan_code = 4'h5;
            4'd6:  scan_code = 4'h6;
            4'd7:  scan_code = 4'hB;
            4'd8:  scan_code = 4'h7;
            4'd9:  scan_code = 4'h8;
            4'd10: scan_code = 4'h9;
            4'd11: scan_code = 4'hC;
            4'd12: scan_code = 4'hE;
            4'd13: scan_code = 4'h0;
            4'd14: scan_code = 4'hF;
            4'd15: scan_code = 4'hD;
            default: scan_code = 4'h0;
        endcase
    end

    // A nonzero press count means the previous scan was a SINGLE with prev_code.
    assign press_inc = ((press_cnt != '0) && (scan_code == prev_code)) ? press_cnt + 1'b1 : CW'(1);
    assign rel_inc   = rel_cnt + 1'b1;
    assign eval_act  = en && (state == EVAL);
    assign push      = eval_act && !key_held && is_single && (press_inc == DB_TARGET);
    assign pop       = key_valid && key_ready;
    assign drop      = push && fifo_full && !pop;

    // Press/release debounce, evaluated once per completed scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_cnt <= '0;
            rel_cnt   <= '0;
            prev_code <= 4'h0;
            key_held  <= 1'b0;
        end else if (!en) begin
            press_cnt <= '0;
            rel_cnt   <= '0;
            key_held  <= 1'b0;
        end else if (state == EVAL) begin
            if (!key_held) begin
                rel_cnt <= '0;
                if (is_single) begin
                    press_cnt <= press_inc;
                    prev_code <= scan_code;
                    if (press_inc == DB_TARGET) key_held <= 1'b1;
                end else begin
                    press_cnt <= '0;
                end
            end else begin
                if (is_single) begin
                    rel_cnt <= '0;
                end else if (rel_inc == DB_TARGET) begin
                    key_held  <= 1'b0;
                    press_cnt <= '0;
                    rel_cnt   <= '0;
                end else begin
                    rel_cnt <= rel_inc;
                end
            end
        end
    end

    // Sticky overflow; a new drop in the same cycle as the clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    keypad_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_key_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (scan_code),
        .pop      (pop),
        .head_dat (key_code),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign key_valid = !fifo_empty;
endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Sequences the 4x4 keypad matrix: drives one row low at a time, samples the active-low columns, debounces, and decodes one keypress into a 4-bit key code.
- Queues decoded keys in a small FIFO with a valid/ready handshake, so the RV32I-side consumer (MMIO register or input FSM) never misses a press.
- Sits between the keypad pins and the core's input logic.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven (row dwell); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans needed to accept a press, and to accept a release.
- FIFO_DEPTH, 4: key FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  scan enable
- columns  in  4  keypad columns, active low, asynchronous to clk
- rows  out  4  row drive, active low, one-cold while scanning
- key_code  out  4  FIFO head code; 0 when FIFO empty
- key_valid  out  1  FIFO not empty
- key_ready  in  1  consumer accepts head when key_valid && key_ready
- key_held  out  1  a debounced key is currently pressed
- overflow  out  1  sticky; a push was dropped while FIFO full
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (and registered outputs): rows=1111, key_code=0, key_valid=0, key_held=0, overflow=0; FIFO empty, state IDLE, debounce counters 0.
- columns pass through a 2-flop synchronizer before use.
- FSM states: IDLE, DRIVE, EVAL.
  - IDLE: rows=1111. If en=1, go to DRIVE with row index 0; rows=1110 on the following cycle.
  - DRIVE: rows = row index r driven low (r=0 gives 1110, r=1 gives 1101, r=2 gives 1011, r=3 gives 0111). The dwell counter runs 0..SCAN_DIV-1. On count SCAN_DIV-1, capture the synchronized columns for row r. If r<3, go to r+1. If r=3, go to EVAL.
  - EVAL: exactly one cycle, rows=1111. Classify the 16 captured bits, then return to DRIVE r=0.
  - Full scan period = 4*SCAN_DIV+1 cycles.
- Scan classification:
  - NONE: all columns 1111.
  - SINGLE: exactly one 0 bit across all rows.
  - MULTI: anything else; treated as NONE for release counting and never emits a code.
- Code map (row, column pattern -> code):
  - row0: 1110->1, 1101->2, 1011->3, 0111->A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: 1110->E, 1101->0, 1011->F, 0111->D
- Debounce (updated only in EVAL):
  - With key_held=0: a SINGLE with the same code as the previous scan increments press_cnt; a different code reloads press_cnt=1. NONE/MULTI clears press_cnt.
  - When press_cnt reaches DEBOUNCE_SCANS: push the code, set key_held=1. Exactly one push per press.
  - With key_held=1: NONE/MULTI increments rel_cnt; a SINGLE clears it. At DEBOUNCE_SCANS, key_held=0 and press_cnt=0.
  - Press-to-valid latency: the push occurs in the EVAL of the DEBOUNCE_SCANS-th consistent scan; key_valid/key_code update the next cycle.
- FIFO:
  - Pop occurs when key_valid && key_ready; key_code shows the next entry (or 0) the following cycle.
  - Push and pop in the same cycle are both performed, including when full; no drop.
  - Push when full without a pop drops the code and sets overflow.
  - clr_overflow clears overflow; a simultaneous new overflow event wins (overflow stays 1).
- en=0 in any state: IDLE next cycle, rows=1111. Counters, row index and key_held are cleared; FIFO and overflow are retained. A re-enable restarts at row 0.
- rst mid-scan returns everything to reset values immediately.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; bench drives columns combinationally from rows.)
- Reset/enable: assert rst -> rows=1111, key_valid=0, overflow=0. Release, en=1 -> rows sequence 1110, 1101, 1011, 0111 (4 cycles each), then 1111 for 1 cycle, repeating every 17 cycles.
- Single press '5' (columns=1101 when rows=1101) held 4 scans, key_ready=0 -> exactly one entry; key_code=5, key_valid=1, key_held=1. Release for 2 scans -> key_held=0. Pulse key_ready -> key_valid=0, key_code=0.
- Bounce and ghosting: '9' present for 1 scan only -> no entry. Keys '1' and '2' pressed together for 4 scans -> no entry, key_held=0.
- Overflow: press/release 1, 2, 3, A, 4 with key_ready=0 -> 4 entries popped in order 1, 2, 3, A; overflow=1. clr_overflow -> overflow=0.
- Full FIFO with key_ready=1 at the push cycle -> push accepted, overflow stays 0.
- Mid-operation: drop en during row 2 -> rows=1111 next cycle, FIFO contents kept. Assert rst during a debounce -> FIFO empty, all outputs at reset values, no later push.
